cart_unlock_rx: RTL and testbench

Console-side initiator and receiver for the cartridge mapper's boot handshake. On request it drives the unlock address (A5h) onto the cartridge address bus for one cycle. It then deframes the 18-bit serial response returned on the cartridge's synchronous-out line and checks the 16-bit payload against the expected word (28A0h). On a match it sets the cartridge-OK bit (SYSTEM_CTRL1 bit 7); it sits between the cartridge slot pins and the system control register file.

---
 rtl/bandai_pkg.sv | 25 ++
 rtl/cart_unlock_rx_if.sv | 12 +
 rtl/cart_unlock_rx.sv | 150 +++++++++++++++
 tb/tb_cart_unlock_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bandai_pkg.sv
// Shared constants and types for the cartridge unlock handshake.
// Used by the receiver RTL and by the mapper model in the bench.
package bandai_pkg;

    localparam logic [7:0] ADDR_NAK  = 8'hA5;
    localparam int         FRAME_LEN = 18;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_NOLINE   = 3'd1;
    localparam logic [2:0] ERR_NORESP   = 3'd2;
    localparam logic [2:0] ERR_FRAME    = 3'd3;
    localparam logic [2:0] ERR_MISMATCH = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_UNLOCK,
        ST_HUNT,
        ST_DATA,
        ST_STOP,
        ST_TAIL,
        ST_FIN
    } stateT;

endpackage

// File: rtl/cart_unlock_rx_if.sv
// Cartridge slot pins touched by the unlock handshake.
// The console is the master: it drives the address bus and listens on SI.
interface cart_unlock_rx_if;

    logic [7:0] ADDR;
    logic       ADDR_OE;
    logic       SI;

    modport master (output ADDR, output ADDR_OE, input SI);
    modport slave  (input ADDR, input ADDR_OE, output SI);

endinterface

// File: rtl/cart_unlock_rx.sv
// Console-side boot handshake: drives the unlock address, deframes the
// mapper's 18-bit reply and raises CART_OK when the payload matches.
module cart_unlock_rx
    import bandai_pkg::*;
#(
    parameter int          TIMEOUT  = 32,
    parameter logic [15:0] EXP_WORD = 16'h28A0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    cart_unlock_rx_if.master cart,
    output logic             BUSY,
    output logic             DONE,
    output logic             CART_OK,
    output logic             ERR,
    output logic [2:0]       ERR_CODE,
    output logic [15:0]      WORD
);

    localparam logic [5:0] LAST_WAIT = 6'(TIMEOUT - 1);

    stateT       state;
    logic [5:0]  stepCnt;
    logic [15:0] shiftReg;
    logic        lineHigh;
    logic        dataDone;
    logic [2:0]  runCode;

    // One FSM owns every output; stepCnt serves as both the wait timer in
    // PREP/HUNT and the bit index in DATA, and restarts on each state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_IDLE;
            stepCnt      <= 6'd0;
            shiftReg     <= 16'h0000;
            lineHigh     <= 1'b0;
            dataDone     <= 1'b0;
            runCode      <= ERR_NONE;
            cart.ADDR    <= 8'h00;
            cart.ADDR_OE <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            CART_OK      <= 1'b0;
            ERR          <= 1'b0;
            ERR_CODE     <= ERR_NONE;
            WORD         <= 16'h0000;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state    <= ST_PREP;
                        stepCnt  <= 6'd0;
                        lineHigh <= 1'b0;
                        dataDone <= 1'b0;
                        runCode  <= ERR_NONE;
                        ERR      <= 1'b0;
                        ERR_CODE <= ERR_NONE;
                        BUSY     <= 1'b1;
                    end
                end
                ST_PREP: begin
                    if (cart.SI && lineHigh) begin
                        state        <= ST_UNLOCK;
                        stepCnt      <= 6'd0;
                        cart.ADDR    <= ADDR_NAK;
                        cart.ADDR_OE <= 1'b1;
                    end else if (stepCnt == LAST_WAIT) begin
                        state   <= ST_FIN;
                        stepCnt <= 6'd0;
                        runCode <= ERR_NOLINE;
                        DONE    <= 1'b1;
                    end else begin
                        stepCnt  <= stepCnt + 6'd1;
                        lineHigh <= cart.SI;
                    end
                end
                ST_UNLOCK: begin
                    state        <= ST_HUNT;
                    stepCnt      <= 6'd0;
                    cart.ADDR    <= 8'h00;
                    cart.ADDR_OE <= 1'b0;
                end
                ST_HUNT: begin
                    if (!cart.SI) begin
                        state   <= ST_DATA;
                        stepCnt <= 6'd0;
                    end else if (stepCnt == LAST_WAIT) begin
                        state   <= ST_FIN;
                        stepCnt <= 6'd0;
                        runCode <= ERR_NORESP;
                        DONE    <= 1'b1;
                    end else begin
                        stepCnt <= stepCnt + 6'd1;
                    end
                end
                ST_DATA: begin
                    shiftReg <= {cart.SI, shiftReg[15:1]};
                    if (stepCnt[3:0] == 4'd15) begin
                        state    <= ST_STOP;
                        stepCnt  <= 6'd0;
                        dataDone <= 1'b1;
                    end else begin
                        stepCnt <= stepCnt + 6'd1;
                    end
                end
                ST_STOP: begin
                    stepCnt <= 6'd0;
                    if (!cart.SI) begin
                        state <= ST_TAIL;
                    end else begin
                        state   <= ST_FIN;
                        runCode <= ERR_FRAME;
                        DONE    <= 1'b1;
                    end
                end
                ST_TAIL: begin
                    state   <= ST_FIN;
                    stepCnt <= 6'd0;
                    DONE    <= 1'b1;
                    if (!cart.SI) begin
                        runCode <= ERR_FRAME;
                    end
                end
                ST_FIN: begin
                    state   <= ST_IDLE;
                    stepCnt <= 6'd0;
                    BUSY    <= 1'b0;
                    if (dataDone) begin
                        WORD <= shiftReg;
                    end
                    if (runCode != ERR_NONE) begin
                        ERR      <= 1'b1;
                        ERR_CODE <= runCode;
                    end else if (shiftReg == EXP_WORD) begin
                        CART_OK <= 1'b1;
                    end else begin
                        ERR      <= 1'b1;
                        ERR_CODE <= ERR_MISMATCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_unlock_rx.sv
// Bench for cart_unlock_rx: a one-shot mapper model answers the unlock,
// and a scenario-level reference predicts code, latency and status.
module tb_cart_unlock_rx;
    import bandai_pkg::*;

    localparam int          TIMEOUT  = 32;
    localparam logic [15:0] EXP_WORD = 16'h28A0;

    localparam int MODE_GOOD       = 0;
    localparam int MODE_SILENT     = 1;
    localparam int MODE_LINELOW    = 2;
    localparam int MODE_BADTRAILER = 3;
    localparam int MODE_BADTAIL    = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        BUSY;
    logic        DONE;
    logic        CART_OK;
    logic        ERR;
    logic [2:0]  ERR_CODE;
    logic [15:0] WORD;

    int checks = 0;
    int passes = 0;

    cart_unlock_rx_if bus();

    cart_unlock_rx #(.TIMEOUT(TIMEOUT), .EXP_WORD(EXP_WORD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .cart     (bus),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .CART_OK  (CART_OK),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE),
        .WORD     (WORD)
    );

    always #5 CLK = ~CLK;

    // Mapper model state and the bench's own view of the expected results.
    bit          mapperSpent  = 1'b0;
    bit          mapperSilent = 1'b0;
    bit          sawUnlock    = 1'b0;
    bit          modelSi      = 1'b1;
    bit          siForceLow   = 1'b0;
    int          mapperFault  = 0;
    logic [15:0] mapperPayload = 16'h0000;
    bit          frameQ[$];

    bit          refSpent  = 1'b0;
    bit          refCartOk = 1'b0;
    logic [15:0] refWord   = 16'h0000;

    assign bus.SI = siForceLow ? 1'b0 : modelSi;

    always @(negedge CLK) sawUnlock = bus.ADDR_OE && (bus.ADDR == ADDR_NAK);

    // The mapper latches its frame on the edge that closes the unlock cycle
    // and then presents one frame bit after every following edge.
    always begin
        @(posedge CLK);
        #1;
        if (sawUnlock && !mapperSpent && !mapperSilent) begin
            mapperSpent = 1'b1;
            frameQ.delete();
            frameQ.push_back(1'b0);
            for (int i = 0; i < FRAME_LEN - 2; i++) frameQ.push_back(mapperPayload[i]);
            frameQ.push_back(mapperFault == MODE_BADTRAILER);
            if (mapperFault == MODE_BADTAIL) frameQ.push_back(1'b0);
        end
        if (frameQ.size() > 0) modelSi = frameQ.pop_front();
        else modelSi = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic cartridgeReset();
        mapperSpent = 1'b0;
        frameQ.delete();
        modelSi  = 1'b1;
        refSpent = 1'b0;
    endtask

    task automatic hardReset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        cartridgeReset();
        refCartOk = 1'b0;
        refWord   = 16'h0000;
    endtask

    task automatic checkResetValues(input string when);
        checkOutput({when, ".addr"},    32'(bus.ADDR),    32'h0);
        checkOutput({when, ".addrOe"},  32'(bus.ADDR_OE), 32'h0);
        checkOutput({when, ".busy"},    32'(BUSY),        32'h0);
        checkOutput({when, ".done"},    32'(DONE),        32'h0);
        checkOutput({when, ".cartOk"},  32'(CART_OK),     32'h0);
        checkOutput({when, ".err"},     32'(ERR),         32'h0);
        checkOutput({when, ".errCode"}, 32'(ERR_CODE),    32'h0);
        checkOutput({when, ".word"},    32'(WORD),        32'h0);
    endtask

    // Scenario-level reference: which failure (if any) a run must report and
    // how many edges after the START edge DONE becomes visible.
    task automatic predict(input int mode, input logic [15:0] payload,
                           output int expLat, output logic [2:0] expCode);
        if (mode == MODE_LINELOW) begin
            expCode = ERR_NOLINE;
            expLat  = TIMEOUT + 1;
        end else if (mode == MODE_SILENT || refSpent) begin
            expCode = ERR_NORESP;
            expLat  = TIMEOUT + 4;
        end else begin
            refSpent = 1'b1;
            refWord  = payload;
            expLat   = 23;
            if (mode == MODE_BADTRAILER) begin
                expCode = ERR_FRAME;
                expLat  = 22;
            end else if (mode == MODE_BADTAIL) begin
                expCode = ERR_FRAME;
            end else if (payload == EXP_WORD) begin
                expCode   = ERR_NONE;
                refCartOk = 1'b1;
            end else begin
                expCode = ERR_MISMATCH;
            end
        end
    endtask

    task automatic applyStimulus(input int mode, input logic [15:0] payload,
                                 input bit glitch, input int resetAt);
        int         expLat;
        logic [2:0] expCode;
        int         cycles;
        int         oeCycles;
        mapperSilent  = (mode == MODE_SILENT);
        mapperFault   = mode;
        mapperPayload = payload;
        siForceLow    = (mode == MODE_LINELOW);
        predict(mode, payload, expLat, expCode);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START    = 1'b0;
        cycles   = 1;
        oeCycles = 0;
        checkOutput("startBusy",    32'(BUSY),     32'h1);
        checkOutput("startErr",     32'(ERR),      32'h0);
        checkOutput("startErrCode", 32'(ERR_CODE), 32'h0);
        while (!DONE && cycles < 200) begin
            if (bus.ADDR_OE) begin
                oeCycles++;
                checkOutput("addrUnlock", 32'(bus.ADDR), 32'(ADDR_NAK));
            end else begin
                checkOutput("addrIdle", 32'(bus.ADDR), 32'h0);
            end
            if (cycles == resetAt) begin
                if (resetAt == 3) checkOutput("oeBeforeReset", 32'(bus.ADDR_OE), 32'h1);
                checkOutput("busyBeforeReset", 32'(BUSY), 32'h1);
                #2;
                RST = 1'b1;
                #1;
                checkResetValues("midRunReset");
                @(negedge CLK);
                RST        = 1'b0;
                START      = 1'b0;
                siForceLow = 1'b0;
                cartridgeReset();
                refCartOk = 1'b0;
                refWord   = 16'h0000;
                return;
            end
            START = glitch && (cycles == 6);
            @(negedge CLK);
            cycles++;
        end
        START = 1'b0;
        checkOutput("donePulse", 32'(DONE), 32'h1);
        checkOutput("latency",   32'(cycles), 32'(expLat));
        checkOutput("busyAtDone", 32'(BUSY), 32'h1);
        checkOutput("oeCycles",  32'(oeCycles), (mode == MODE_LINELOW) ? 32'h0 : 32'h1);
        @(negedge CLK);
        siForceLow = 1'b0;
        checkOutput("doneWidth", 32'(DONE),     32'h0);
        checkOutput("busyAfter", 32'(BUSY),     32'h0);
        checkOutput("cartOk",    32'(CART_OK),  32'(refCartOk));
        checkOutput("err",       32'(ERR),      32'(expCode != ERR_NONE));
        checkOutput("errCode",   32'(ERR_CODE), 32'(expCode));
        checkOutput("word",      32'(WORD),     32'(refWord));
    endtask

    initial begin
        int          r;
        int          mode;
        logic [15:0] payload;
        RST   = 1'b1;
        START = 1'b0;
        repeat (2) @(negedge CLK);
        checkResetValues("reset");
        RST = 1'b0;
        @(negedge CLK);

        applyStimulus(MODE_GOOD, EXP_WORD, 1'b0, -1);
        applyStimulus(MODE_GOOD, EXP_WORD, 1'b1, -1);

        hardReset();
        applyStimulus(MODE_GOOD, 16'h28A1, 1'b0, -1);

        hardReset();
        applyStimulus(MODE_SILENT, EXP_WORD, 1'b0, -1);
        applyStimulus(MODE_SILENT, EXP_WORD, 1'b1, -1);
        applyStimulus(MODE_LINELOW, EXP_WORD, 1'b0, -1);

        cartridgeReset();
        applyStimulus(MODE_BADTRAILER, EXP_WORD, 1'b0, -1);
        cartridgeReset();
        applyStimulus(MODE_BADTAIL, EXP_WORD, 1'b0, -1);

        cartridgeReset();
        applyStimulus(MODE_GOOD, EXP_WORD, 1'b0, -1);
        cartridgeReset();
        applyStimulus(MODE_GOOD, EXP_WORD, 1'b0, 12);
        applyStimulus(MODE_GOOD, EXP_WORD, 1'b0, 3);
        applyStimulus(MODE_GOOD, EXP_WORD, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            r       = int'($urandom_range(0, 9));
            mode    = (r < 5) ? MODE_GOOD : r - 5;
            payload = ($urandom_range(0, 2) == 0) ? EXP_WORD : 16'($urandom);
            if ($urandom_range(0, 3) != 0) cartridgeReset();
            if ($urandom_range(0, 9) == 0) hardReset();
            applyStimulus(mode, payload, 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
